// File: rtl/musa_program_loader.sv
// Boot-time loader: takes a framed byte stream, writes big-endian words into instruction memory,
// verifies the XOR checksum and releases the core from reset only on success.
module musa_program_loader #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,  // active-high despite the name
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  input  logic                  reload_i,
  output logic [ADDR_WIDTH-1:0] imem_address_o,
  output logic [31:0]           imem_data_o,
  output logic                  imem_wren_o,
  output logic                  core_rst_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  if (MAX_WORDS > 65535 || (ADDR_WIDTH < 32 && 64'(MAX_WORDS) > (64'd1 << ADDR_WIDTH))) begin : g_chk
    $error("MAX_WORDS must fit both the 16-bit header and the address space");
  end

  typedef enum logic [2:0] {
    StHdrHi, StHdrLo, StData, StWrite, StCheck, StDone, StErr
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            hi_q, hi_d;
  logic [15:0]           n_q, n_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  wren_q, wren_d;
  logic                  rdy_q, rdy_d;
  logic                  crst_q, crst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic        accept;
  logic [15:0] hdr_n;

  assign accept = rx_valid_i && rdy_q;
  assign hdr_n  = {hi_q, rx_data_i};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;

    unique case (state_q)
      StHdrHi: begin
        if (accept) begin
          hi_d    = rx_data_i;
          state_d = StHdrLo;
        end
      end
      StHdrLo: begin
        if (accept) begin
          n_d = hdr_n;
          if (32'(hdr_n) > MAX_WORDS) state_d = StErr;
          else if (hdr_n == 16'd0)    state_d = StCheck;
          else                        state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          asm_d  = {asm_q[15:0], rx_data_i};
          csum_d = csum_q ^ rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          // Fourth byte completes the word; launch the write from the unshifted value.
          if (bcnt_q == 2'd3) begin
            state_d = StWrite;
            wren_d  = 1'b1;
            addr_d  = ADDR_WIDTH'(idx_q);
            data_d  = {asm_q, rx_data_i};
          end
        end
      end
      StWrite: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_q + 16'd1 == n_q) ? StCheck : StData;
      end
      StCheck: begin
        if (accept) state_d = (rx_data_i == csum_q) ? StDone : StErr;
      end
      StDone, StErr: begin
        if (reload_i) begin
          state_d = StHdrHi;
          idx_d   = '0;
          bcnt_d  = '0;
          csum_d  = '0;
          n_d     = '0;
          hi_d    = '0;
          asm_d   = '0;
        end
      end
      default: state_d = StHdrHi;
    endcase

    rdy_d  = (state_d == StHdrHi) || (state_d == StHdrLo) ||
             (state_d == StData)  || (state_d == StCheck);
    busy_d = (state_d != StDone) && (state_d != StErr);
    done_d = (state_d == StDone);
    err_d  = (state_d == StErr);
    crst_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_q <= StHdrHi;
      hi_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      rdy_q   <= 1'b1;
      crst_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      rdy_q   <= rdy_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_ready_o     = rdy_q;
  assign imem_address_o = addr_q;
  assign imem_data_o    = data_q;
  assign imem_wren_o    = wren_q;
  assign core_rst_n_o   = crst_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_musa_program_loader.sv
// Randomised bench for musa_program_loader: frames are built here, expected writes and outcome
// come from a byte-level frame model, and observed memory writes are captured by a monitor.
module tb_musa_program_loader;
  localparam int AW   = 18;
  localparam int MAXW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          reload = 1'b0;
  logic          rx_ready, imem_wren, core_rst_n, busy, done, error;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_data;

  musa_program_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .rx_ready_o    (rx_ready),
    .reload_i      (reload),
    .imem_address_o(imem_address),
    .imem_data_o   (imem_data),
    .imem_wren_o   (imem_wren),
    .core_rst_n_o  (core_rst_n),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    frame[$];
  logic [31:0]   exp_words[$];
  bit            exp_err;
  int            exp_nbytes;
  logic [31:0]   got_data[$];
  logic [AW-1:0] got_addr[$];
  bit            watch_crst = 1'b0;
  int            crst_high = 0;

  // Capture every write; the loader must never offer ready while writing.
  always @(negedge clk) begin
    if (imem_wren === 1'b1) begin
      got_addr.push_back(imem_address);
      got_data.push_back(imem_data);
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_rx_ready got %b exp 0", rx_ready);
      end
    end
    if (watch_crst && core_rst_n !== 1'b0) crst_high++;
  end

  function automatic void build_frame(input logic [15:0] n);
    frame.delete();
    frame.push_back(n[15:8]);
    frame.push_back(n[7:0]);
    for (int i = 0; i < 4 * int'(n); i++) frame.push_back(8'($urandom));
  endfunction

  function automatic logic [7:0] data_xor();
    logic [7:0] x = '0;
    for (int i = 2; i < frame.size(); i++) x ^= frame[i];
    return x;
  endfunction

  // Frame-level reference: words in order, then accept/reject by checksum or header range.
  function automatic void model();
    int unsigned n;
    logic [7:0]  cs = '0;
    logic [31:0] word;
    n = {frame[0], frame[1]};
    exp_words.delete();
    if (n > MAXW) begin
      exp_err    = 1'b1;
      exp_nbytes = 2;
      return;
    end
    for (int w = 0; w < int'(n); w++) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        word = (word << 8) | 32'(frame[2 + 4 * w + k]);
        cs ^= frame[2 + 4 * w + k];
      end
      exp_words.push_back(word);
    end
    exp_nbytes = 2 + 4 * int'(n) + 1;
    exp_err    = (frame[exp_nbytes - 1] != cs);
  endfunction

  task automatic reset_dut();
    rx_valid = 1'b0;
    reload   = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    got_addr.delete();
    got_data.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
    waited = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (rx_ready === 1'b1) begin
        @(posedge clk);
        #1 rx_valid = 1'b0;
        return;
      end
      waited++;
    end
    rx_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL byte_accept_timeout got waited=%0d exp accept within 64 cycles", waited);
  endtask

  task automatic drive_frame(input int maxgap);
    int w;
    for (int i = 0; i < exp_nbytes; i++) send_byte(frame[i], $urandom_range(maxgap, 0), w);
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || error !== 1'b0 ||
        core_rst_n !== 1'b0 || imem_wren !== 1'b0 || imem_address !== '0 || imem_data !== '0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b busy=%b done=%b err=%b crst=%b wren=%b addr=%h data=%h exp 1 1 0 0 0 0 0 0",
               rx_ready, busy, done, error, core_rst_n, imem_wren, imem_address, imem_data);
    end
  endtask

  task automatic test_basic(input bit bad);
    reset_dut();
    frame = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
    frame.push_back(bad ? 8'h00 : data_xor());
    model();
    drive_frame(2);
    repeat (2) @(negedge clk);
    checks++;
    if (got_data.size() != 2 || exp_words.size() != 2) begin
      errors++;
      $display("FAIL basic_nwrites got %0d exp 2", got_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_addr[i] !== AW'(i) || got_data[i] !== exp_words[i]) begin
          errors++;
          $display("FAIL basic_write%0d got %h@%0d exp %h@%0d", i, got_data[i], got_addr[i],
                   exp_words[i], i);
        end
      end
    end
    checks++;
    if (done !== !exp_err || error !== exp_err || core_rst_n !== !exp_err || rx_ready !== 1'b0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_outcome bad=%0d got done=%b err=%b crst=%b rdy=%b busy=%b exp %b %b %b 0 0",
               bad, done, error, core_rst_n, rx_ready, busy, !exp_err, exp_err, !exp_err);
    end
  endtask

  task automatic test_header_limits();
    reset_dut();
    frame = '{8'h01, 8'h01};
    model();
    drive_frame(1);
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || core_rst_n !== 1'b0 || got_data.size() != 0) begin
      errors++;
      $display("FAIL hdr_257 got err=%b done=%b crst=%b writes=%0d exp 1 0 0 0",
               error, done, core_rst_n, got_data.size());
    end
    for (int v = 0; v < 2; v++) begin
      reset_dut();
      frame = '{8'h00, 8'h00};
      frame.push_back(v == 0 ? 8'h00 : 8'h5A);
      model();
      drive_frame(3);
      repeat (2) @(negedge clk);
      checks++;
      if (done !== !exp_err || error !== exp_err || core_rst_n !== !exp_err ||
          got_data.size() != 0) begin
        errors++;
        $display("FAIL hdr_zero cs=%h got done=%b err=%b crst=%b writes=%0d exp %b %b %b 0",
                 frame[2], done, error, core_rst_n, got_data.size(), !exp_err, exp_err, !exp_err);
      end
    end
    // Largest legal image.
    reset_dut();
    build_frame(16'(MAXW));
    frame.push_back(data_xor());
    model();
    drive_frame(1);
    repeat (2) @(negedge clk);
    checks++;
    if (got_data.size() != MAXW || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL hdr_max got writes=%0d done=%b err=%b exp %0d 1 0",
               got_data.size(), done, error, MAXW);
    end else begin
      for (int i = 0; i < MAXW; i++) begin
        checks++;
        if (got_addr[i] !== AW'(i) || got_data[i] !== exp_words[i]) begin
          errors++;
          $display("FAIL hdr_max_write%0d got %h@%0d exp %h", i, got_data[i], got_addr[i],
                   exp_words[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int w;
    reset_dut();
    build_frame(16'd2);
    frame.push_back(data_xor());
    model();
    // Back-to-back bytes: the first byte of word 1 lands on the WRITE cycle.
    for (int i = 0; i < exp_nbytes; i++) begin
      send_byte(frame[i], 0, w);
      if (i == 6) begin
        checks++;
        if (w != 1) begin
          errors++;
          $display("FAIL stall_write_wait got %0d exp 1", w);
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_data.size() != 2 || got_data[0] !== exp_words[0] || got_data[1] !== exp_words[1] ||
        done !== 1'b1) begin
      errors++;
      $display("FAIL stall_writes got n=%0d done=%b exp n=2 done=1", got_data.size(), done);
    end
    for (int it = 0; it < 6; it++) begin
      reset_dut();
      build_frame(16'($urandom_range(6, 1)));
      frame.push_back(data_xor() ^ (($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 1)) : 8'h00));
      model();
      drive_frame(4);
      repeat (2) @(negedge clk);
      checks++;
      if (got_data.size() != exp_words.size()) begin
        errors++;
        $display("FAIL rand%0d_nwrites got %0d exp %0d", it, got_data.size(), exp_words.size());
      end else begin
        foreach (exp_words[i]) begin
          checks++;
          if (got_addr[i] !== AW'(i) || got_data[i] !== exp_words[i]) begin
            errors++;
            $display("FAIL rand%0d_write%0d got %h@%0d exp %h", it, i, got_data[i], got_addr[i],
                     exp_words[i]);
          end
        end
      end
      checks++;
      if (done !== !exp_err || error !== exp_err || core_rst_n !== !exp_err) begin
        errors++;
        $display("FAIL rand%0d_outcome got done=%b err=%b crst=%b exp %b %b %b", it, done, error,
                 core_rst_n, !exp_err, exp_err, !exp_err);
      end
    end
  endtask

  task automatic test_async_reset();
    int w;
    reset_dut();
    build_frame(16'd2);
    frame.push_back(data_xor());
    for (int i = 0; i < 4; i++) send_byte(frame[i], $urandom_range(2, 0), w);
    rx_valid = 1'b1;
    rx_data  = frame[4];
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_wren !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1 || imem_data !== '0 ||
        imem_address !== '0 || core_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_values got wren=%b busy=%b rdy=%b data=%h addr=%h crst=%b exp 0 1 1 0 0 0",
               imem_wren, busy, rx_ready, imem_data, imem_address, core_rst_n);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if (got_data.size() != 0) begin
      errors++;
      $display("FAIL async_aborted_write got %0d writes exp 0", got_data.size());
    end
    build_frame(16'($urandom_range(3, 1)));
    frame.push_back(data_xor());
    model();
    drive_frame(2);
    repeat (2) @(negedge clk);
    checks++;
    if (got_data.size() != exp_words.size() || done !== 1'b1) begin
      errors++;
      $display("FAIL async_fresh got writes=%0d done=%b exp %0d 1", got_data.size(), done,
               exp_words.size());
    end else begin
      foreach (exp_words[i]) begin
        checks++;
        if (got_addr[i] !== AW'(i) || got_data[i] !== exp_words[i]) begin
          errors++;
          $display("FAIL async_fresh_write%0d got %h@%0d exp %h", i, got_data[i], got_addr[i],
                   exp_words[i]);
        end
      end
    end
  endtask

  task automatic test_reload();
    reset_dut();
    build_frame(16'd1);
    frame.push_back(data_xor());
    model();
    drive_frame(2);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    watch_crst = 1'b1;
    checks++;
    if (core_rst_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_entry got crst=%b busy=%b done=%b rdy=%b exp 0 1 0 1",
               core_rst_n, busy, done, rx_ready);
    end
    got_addr.delete();
    got_data.delete();
    frame = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    model();
    drive_frame(3);
    watch_crst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (crst_high != 0) begin
      errors++;
      $display("FAIL reload_core_rst got %0d cycles high exp 0", crst_high);
    end
    checks++;
    if (got_data.size() != 1 || got_addr[0] !== '0 || got_data[0] !== 32'hFFFF_FFFF ||
        done !== 1'b1 || core_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL reload_frame got writes=%0d done=%b crst=%b exp 1 write of ffffffff@0, 1 1",
               got_data.size(), done, core_rst_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_header_limits();
    test_stall();
    test_async_reset();
    test_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
